// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/memory arbiter: state encoding, burst geometry and
// the ripple-carry adder used by the burst address generator.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StFillI = 2'd2,
        StFillD = 2'd3
    } arb_state_e;

    // Memory read latency; the arbiter never counts it, it only waits for mem_data_valid.
    localparam int unsigned MEM_LATENCY       = 4;
    localparam int unsigned WORDS_PER_BLOCK   = 8;
    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned WORD_STRIDE       = 2;
    localparam int unsigned CNT_W             = 4;

    localparam logic [CNT_W-1:0] BURST_LEN  = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

    function automatic logic [15:0] rca_16bit(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic        carry;
        carry = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        return s;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_burst_ctrl.sv
// Burst bookkeeping for one 8-word block fill: issue/return counters, block base latch and the
// per-word read address generator.
module mem_burst_ctrl
    import cache_mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] miss_addr,
    input  logic        issue,
    input  logic        ret,
    output logic [15:0] issue_addr,
    output logic        issue_done,
    output logic        ret_done
);

    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [15:0]      base_q, base_d;
    logic [15:0]      offset;

    assign issue_done = (issue_cnt_q >= BURST_LEN);
    // Done one cycle early when the last word is returning, so the fill spans 8+latency cycles.
    assign ret_done   = (ret_cnt_q >= BURST_LEN) || (ret && (ret_cnt_q == BURST_LAST));

    assign offset     = {11'b0, issue_cnt_q, 1'b0};
    assign issue_addr = rca_16bit(base_q, offset);

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        base_d      = base_q;
        if (start) begin
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            base_d      = {miss_addr[15:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
        end else begin
            if (issue && !issue_done) begin
                issue_cnt_d = issue_cnt_q + 1'b1;
            end
            if (ret && (ret_cnt_q < BURST_LEN)) begin
                ret_cnt_d = ret_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_q      <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_q      <= base_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared pipelined memory between I-cache fills, D-cache fills and D-cache
// write-through stores; one owner at a time with a mandatory idle cycle between owners.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_req,
    input  logic [15:0] icache_addr,
    input  logic        dcache_req,
    input  logic [15:0] dcache_addr,
    input  logic        dcache_wr_req,
    input  logic [15:0] dcache_wr_addr,
    input  logic [15:0] dcache_wr_data,
    output logic        icache_grant,
    output logic        dcache_grant,
    output logic        dcache_wr_ack,
    output logic        icache_data_valid,
    output logic        dcache_data_valid,
    output logic [15:0] fill_data,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid
);

    arb_state_e  state_q, state_d;
    logic        start;
    logic        fill_active;
    logic        ret;
    logic        issue_done;
    logic        ret_done;
    logic [15:0] miss_addr;
    logic [15:0] issue_addr;

    assign fill_active = (state_q == StFillI) || (state_q == StFillD);
    // Returns are only counted while a fill owns the port; stray strobes elsewhere are dropped.
    assign ret         = fill_active && mem_data_valid;
    assign miss_addr   = dcache_req ? dcache_addr : icache_addr;
    assign fill_data   = mem_data_out;

    mem_burst_ctrl u_burst_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .miss_addr (miss_addr),
        .issue     (fill_active),
        .ret       (ret),
        .issue_addr(issue_addr),
        .issue_done(issue_done),
        .ret_done  (ret_done)
    );

    always_comb begin
        state_d           = state_q;
        start             = 1'b0;
        icache_grant      = 1'b0;
        dcache_grant      = 1'b0;
        dcache_wr_ack     = 1'b0;
        icache_data_valid = 1'b0;
        dcache_data_valid = 1'b0;
        mem_enable        = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = 16'h0;
        mem_data_in       = 16'h0;
        case (state_q)
            StIdle: begin
                if (dcache_wr_req) begin
                    state_d = StWrite;
                end else if (dcache_req) begin
                    start   = 1'b1;
                    state_d = StFillD;
                end else if (icache_req) begin
                    start   = 1'b1;
                    state_d = StFillI;
                end
            end
            StWrite: begin
                mem_enable    = 1'b1;
                mem_wr        = 1'b1;
                mem_addr      = dcache_wr_addr;
                mem_data_in   = dcache_wr_data;
                dcache_wr_ack = 1'b1;
                state_d       = StIdle;
            end
            StFillI: begin
                icache_grant      = 1'b1;
                mem_enable        = !issue_done;
                mem_addr          = issue_done ? 16'h0 : issue_addr;
                icache_data_valid = mem_data_valid;
                if (ret_done) begin
                    state_d = StIdle;
                end
            end
            StFillD: begin
                dcache_grant      = 1'b1;
                mem_enable        = !issue_done;
                mem_addr          = issue_done ? 16'h0 : issue_addr;
                dcache_data_valid = mem_data_valid;
                if (ret_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a latency-4 memory model, an issue/return
// scoreboard, a vector table, a fill table and hand-written contention/reset sequences.
module tb_cache_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_req, dcache_req, dcache_wr_req;
    logic [15:0] icache_addr, dcache_addr, dcache_wr_addr, dcache_wr_data;
    logic        icache_grant, dcache_grant, dcache_wr_ack;
    logic        icache_data_valid, dcache_data_valid;
    logic [15:0] fill_data;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_data_valid;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .icache_req       (icache_req),
        .icache_addr      (icache_addr),
        .dcache_req       (dcache_req),
        .dcache_addr      (dcache_addr),
        .dcache_wr_req    (dcache_wr_req),
        .dcache_wr_addr   (dcache_wr_addr),
        .dcache_wr_data   (dcache_wr_data),
        .icache_grant     (icache_grant),
        .dcache_grant     (dcache_grant),
        .dcache_wr_ack    (dcache_wr_ack),
        .icache_data_valid(icache_data_valid),
        .dcache_data_valid(dcache_data_valid),
        .fill_data        (fill_data),
        .mem_enable       (mem_enable),
        .mem_wr           (mem_wr),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .mem_data_valid   (mem_data_valid)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Memory model: not tied to rst_n so in-flight reads still come back after a DUT reset.
    logic           mem_clr;
    logic           stray;
    logic [15:0]    stray_data;
    logic [LAT-1:0] pipe_v;
    logic [15:0]    pipe_a [LAT];

    always @(posedge clk) begin
        if (mem_clr) begin
            pipe_v <= '0;
        end else begin
            pipe_v <= {pipe_v[LAT-2:0], mem_enable & ~mem_wr};
        end
        pipe_a[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end

    assign mem_data_valid = pipe_v[LAT-1] | stray;
    assign mem_data_out   = stray ? stray_data :
                            (pipe_v[LAT-1] ? memf(pipe_a[LAT-1]) : 16'h0);

    typedef struct packed {
        logic        dside;
        logic [15:0] data;
    } sb_t;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    sb_t         sb_q[$];
    logic [15:0] addr_q[$];
    wr_t         wr_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic grant_of(input logic dside);
        return dside ? dcache_grant : icache_grant;
    endfunction

    // One clock: monitor the current cycle at the falling edge, then step to just after the
    // next rising edge where stimulus may change.
    task automatic cyc();
        sb_t e;
        wr_t w;
        @(negedge clk);
        check("owner_excl", 32'(((32'(icache_grant) + 32'(dcache_grant) + 32'(dcache_wr_ack))
                                 <= 32'd1)), 1);
        check("wr_without_en", {31'b0, mem_wr & ~mem_enable}, 0);
        check("wr_during_grant", {31'b0, mem_wr & (icache_grant | dcache_grant)}, 0);
        check("ack_without_wr", {31'b0, dcache_wr_ack & ~(mem_enable & mem_wr)}, 0);
        if (mem_enable && !mem_wr) begin
            if (addr_q.size() == 0) begin
                check("issue_unexpected", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                check("issue_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
                sb_q.push_back('{dside: dcache_grant, data: memf(mem_addr)});
            end
        end
        if (mem_enable && mem_wr) begin
            if (wr_q.size() == 0) begin
                check("write_unexpected", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                w = wr_q.pop_front();
                check("write_addr", {16'h0, mem_addr}, {16'h0, w.a});
                check("write_data", {16'h0, mem_data_in}, {16'h0, w.d});
            end
        end
        if (icache_data_valid || dcache_data_valid) begin
            check("valid_both", {31'b0, icache_data_valid & dcache_data_valid}, 0);
            check("valid_without_mem", {31'b0, ~mem_data_valid}, 0);
            if (sb_q.size() == 0) begin
                check("valid_unexpected", {16'h0, fill_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("valid_side", {31'b0, dcache_data_valid}, {31'b0, e.dside});
                check("fill_data", {16'h0, fill_data}, {16'h0, e.data});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fill(input logic [15:0] base);
        for (int i = 0; i < 8; i++) addr_q.push_back(base + 16'(2 * i));
    endtask

    task automatic wait_grant(input logic dside, input int exp_wait);
        int n = 0;
        while (!grant_of(dside) && n < 50) begin
            cyc();
            n++;
        end
        check(dside ? "dgrant_latency" : "igrant_latency", n, exp_wait);
    endtask

    task automatic count_grant(input logic dside, input int exp_len);
        int n = 0;
        while (grant_of(dside) && n < 40) begin
            cyc();
            n++;
        end
        check(dside ? "dgrant_length" : "igrant_length", n, exp_len);
    endtask

    task automatic check_drained();
        check("sb_drained", sb_q.size(), 0);
        check("issues_drained", addr_q.size(), 0);
        check("writes_drained", wr_q.size(), 0);
    endtask

    task automatic run_fill(input logic dside, input logic [15:0] addr, input logic [15:0] base);
        if (dside) begin
            dcache_req  = 1'b1;
            dcache_addr = addr;
        end else begin
            icache_req  = 1'b1;
            icache_addr = addr;
        end
        expect_fill(base);
        wait_grant(dside, 1);
        dcache_req = 1'b0;
        icache_req = 1'b0;
        count_grant(dside, 12);
        check("idle_after_fill", {30'b0, icache_grant, dcache_grant}, 0);
        check_drained();
    endtask

    typedef struct {
        logic        rst;
        logic        stray;
        logic [15:0] sdata;
        logic        wr_req;
        logic        push_wr;
        logic        exp_ack;
        logic        exp_en;
        logic        exp_wr;
    } vec_t;

    typedef struct {
        logic        dside;
        logic [15:0] addr;
        logic [15:0] base;
    } fill_t;

    vec_t  vecs[7];
    fill_t fills[5];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'hA5A5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        fills[0] = '{1'b0, 16'h1236, 16'h1230};
        fills[1] = '{1'b1, 16'h4008, 16'h4000};
        fills[2] = '{1'b0, 16'hFFFE, 16'hFFF0};
        fills[3] = '{1'b1, 16'h000F, 16'h0000};
        fills[4] = '{1'b0, 16'h8A5C, 16'h8A50};

        rst_n          = 1'b0;
        mem_clr        = 1'b1;
        stray          = 1'b0;
        stray_data     = 16'h0;
        icache_req     = 1'b0;
        dcache_req     = 1'b0;
        dcache_wr_req  = 1'b0;
        icache_addr    = 16'h0;
        dcache_addr    = 16'h0;
        dcache_wr_addr = 16'h0010;
        dcache_wr_data = 16'h5555;
        @(posedge clk);
        #1;
        mem_clr = 1'b0;

        // Reset, stray strobes and a lone store.
        for (int i = 0; i < 7; i++) begin
            rst_n         = vecs[i].rst;
            stray         = vecs[i].stray;
            stray_data    = vecs[i].sdata;
            dcache_wr_req = vecs[i].wr_req;
            if (vecs[i].push_wr) wr_q.push_back('{a: 16'h0010, d: 16'h5555});
            #1;
            check("vec_grants", {30'b0, icache_grant, dcache_grant}, 0);
            check("vec_valids", {30'b0, icache_data_valid, dcache_data_valid}, 0);
            check("vec_ack", {31'b0, dcache_wr_ack}, {31'b0, vecs[i].exp_ack});
            check("vec_en", {31'b0, mem_enable}, {31'b0, vecs[i].exp_en});
            check("vec_wr", {31'b0, mem_wr}, {31'b0, vecs[i].exp_wr});
            if (!vecs[i].exp_en) check("vec_addr", {16'h0, mem_addr}, 0);
            cyc();
        end
        stray = 1'b0;
        check_drained();

        // Single fills of both kinds across several block bases.
        for (int i = 0; i < 5; i++) run_fill(fills[i].dside, fills[i].addr, fills[i].base);

        // Simultaneous misses: D first, I after exactly one idle cycle.
        icache_req  = 1'b1;
        icache_addr = 16'h2468;
        dcache_req  = 1'b1;
        dcache_addr = 16'h4008;
        expect_fill(16'h4000);
        expect_fill(16'h2460);
        wait_grant(1'b1, 1);
        check("contend_i_waits", {31'b0, icache_grant}, 0);
        dcache_req = 1'b0;
        count_grant(1'b1, 12);
        check("contend_idle_gap", {30'b0, icache_grant, dcache_grant}, 0);
        cyc();
        check("contend_i_grant", {31'b0, icache_grant}, 1);
        icache_req = 1'b0;
        count_grant(1'b0, 12);
        check_drained();

        // Store beats a pending I miss.
        dcache_wr_req  = 1'b1;
        dcache_wr_addr = 16'h2002;
        dcache_wr_data = 16'hBEEF;
        wr_q.push_back('{a: 16'h2002, d: 16'hBEEF});
        icache_req  = 1'b1;
        icache_addr = 16'h3010;
        expect_fill(16'h3010);
        cyc();
        check("store_first_ack", {31'b0, dcache_wr_ack}, 1);
        check("store_first_noi", {31'b0, icache_grant}, 0);
        cyc();
        dcache_wr_req = 1'b0;
        check("store_then_idle", {30'b0, icache_grant, dcache_wr_ack}, 0);
        cyc();
        check("store_then_i", {31'b0, icache_grant}, 1);
        icache_req = 1'b0;
        count_grant(1'b0, 12);
        check_drained();

        // Store raised mid-burst waits for the fill and the idle cycle.
        icache_req  = 1'b1;
        icache_addr = 16'h7774;
        expect_fill(16'h7770);
        wait_grant(1'b0, 1);
        icache_req = 1'b0;
        repeat (7) cyc();
        dcache_wr_req  = 1'b1;
        dcache_wr_addr = 16'h3004;
        dcache_wr_data = 16'hCAFE;
        wr_q.push_back('{a: 16'h3004, d: 16'hCAFE});
        count_grant(1'b0, 5);
        check("midstore_idle_ack", {31'b0, dcache_wr_ack}, 0);
        cyc();
        check("midstore_ack", {31'b0, dcache_wr_ack}, 1);
        cyc();
        dcache_wr_req = 1'b0;
        check("midstore_ack_pulse", {31'b0, dcache_wr_ack}, 0);
        check_drained();

        // Reset after five returns; late returns must not leak out.
        dcache_req  = 1'b1;
        dcache_addr = 16'h6664;
        expect_fill(16'h6660);
        wait_grant(1'b1, 1);
        dcache_req = 1'b0;
        repeat (9) cyc();
        check("pre_reset_returns", 32'(sb_q.size()), 3);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("reset_idle_grant", {30'b0, icache_grant, dcache_grant}, 0);
        check("reset_idle_en", {31'b0, mem_enable}, 0);
        sb_q.delete();
        addr_q.delete();
        repeat (4) cyc();
        check_drained();
        run_fill(1'b1, 16'h9ABC, 16'h9AB0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
